int_ctrl: RTL and testbench

Parametrised vectored interrupt controller that replaces the control unit's single `hwint` line and fixed hardware vector. It latches up to NUM_IRQ sources with per-channel edge/level mode and enable. It arbitrates by fixed priority and tracks in-service channels so a higher-priority interrupt can preempt a lower one. It presents one `hwint` request plus a computed vector to the control unit and consumes an acknowledge and end-of-interrupt (EOI) handshake.

---
 rtl/int_ctrl.sv | 145 ++++++++++++++
 tb/tb_int_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/int_ctrl.sv
// Vectored interrupt controller: latches edge/level sources, arbitrates by fixed
// priority with in-service nesting, and drives hwint/vector to the control unit.
module int_ctrl #(
    parameter int unsigned      NUM_IRQ    = 8,
    parameter int unsigned      WIDTH      = 32,
    parameter logic [WIDTH-1:0] VEC_BASE   = 32'h0000_0010,
    parameter int unsigned      VEC_STRIDE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] edge_mode,
    input  logic [NUM_IRQ-1:0] en_mask,
    input  logic               imask,
    input  logic               int_ack,
    input  logic               eoi,
    output logic               hwint,
    output logic [WIDTH-1:0]   vector,
    output logic [NUM_IRQ-1:0] pending,
    output logic [NUM_IRQ-1:0] in_service,
    output logic               busy
);

    localparam int unsigned IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    function automatic logic [NUM_IRQ-1:0] lowest_onehot(input logic [NUM_IRQ-1:0] v);
        return v & (~v + NUM_IRQ'(1));
    endfunction

    state_t             state_r, state_nx_s;
    logic [NUM_IRQ-1:0] irq_q_r;
    logic               armed_r;
    logic [NUM_IRQ-1:0] pending_r, pending_nx_s;
    logic [NUM_IRQ-1:0] in_service_r, in_service_nx_s;
    logic [NUM_IRQ-1:0] set_s, cand_s, ack_set_s, eoi_clr_s;
    logic [IDX_W-1:0]   winner_r, winner_nx_s, elig_idx_s;
    logic               elig_vld_s;
    logic               hwint_r, hwint_nx_s, busy_r;
    logic [WIDTH-1:0]   vector_r, vector_nx_s, vec_s;
    int                 lim_s;

    // Source capture; armed_r keeps a source already high at reset release from looking like an edge.
    always_comb begin
        set_s = (edge_mode & irq & ~irq_q_r & {NUM_IRQ{armed_r}}) | (~edge_mode & irq);
    end

    // Fixed-priority arbitration limited to channels above the highest-priority in-service one.
    always_comb begin
        cand_s     = pending_r & en_mask;
        lim_s      = int'(NUM_IRQ);
        elig_vld_s = 1'b0;
        elig_idx_s = '0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            lim_s = in_service_r[i] ? i : lim_s;
        end
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            elig_vld_s = (cand_s[i] && (i < lim_s)) ? 1'b1 : elig_vld_s;
            elig_idx_s = (cand_s[i] && (i < lim_s)) ? IDX_W'(i) : elig_idx_s;
        end
        vec_s = VEC_BASE + (WIDTH'(elig_idx_s) * WIDTH'(VEC_STRIDE));
    end

    // FSM next state, registered-output next values and pending/in-service updates.
    always_comb begin
        state_nx_s  = state_r;
        winner_nx_s = winner_r;
        hwint_nx_s  = 1'b0;
        vector_nx_s = {WIDTH{1'b0}};
        ack_set_s   = {NUM_IRQ{1'b0}};
        case (state_r)
            IDLE: begin
                if (imask && elig_vld_s) begin
                    state_nx_s  = REQ;
                    winner_nx_s = elig_idx_s;
                    hwint_nx_s  = 1'b1;
                    vector_nx_s = vec_s;
                end else begin
                    state_nx_s  = IDLE;
                end
            end
            REQ: begin
                if (int_ack) begin
                    state_nx_s = IDLE;
                    ack_set_s  = NUM_IRQ'(1) << winner_r;
                end else if (!imask || !en_mask[winner_r]) begin
                    state_nx_s = IDLE;
                end else begin
                    hwint_nx_s  = 1'b1;
                    vector_nx_s = vector_r;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
        eoi_clr_s       = eoi ? lowest_onehot(in_service_r) : {NUM_IRQ{1'b0}};
        // A fresh event arriving with the ack survives the clear.
        pending_nx_s    = (pending_r & ~ack_set_s) | set_s;
        in_service_nx_s = (in_service_r & ~eoi_clr_s) | ack_set_s;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q_r      <= {NUM_IRQ{1'b0}};
            armed_r      <= 1'b0;
            pending_r    <= {NUM_IRQ{1'b0}};
            in_service_r <= {NUM_IRQ{1'b0}};
            winner_r     <= {IDX_W{1'b0}};
            hwint_r      <= 1'b0;
            vector_r     <= {WIDTH{1'b0}};
            busy_r       <= 1'b0;
        end else begin
            irq_q_r      <= irq;
            armed_r      <= 1'b1;
            pending_r    <= pending_nx_s;
            in_service_r <= in_service_nx_s;
            winner_r     <= winner_nx_s;
            hwint_r      <= hwint_nx_s;
            vector_r     <= vector_nx_s;
            busy_r       <= |in_service_nx_s;
        end
    end

    assign hwint      = hwint_r;
    assign vector     = vector_r;
    assign pending    = pending_r;
    assign in_service = in_service_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_int_ctrl.sv
// Scoreboard bench for int_ctrl: expectations are queued with each stimulus step
// and compared against the DUT after the following clock edge.
module tb_int_ctrl;
    localparam int N = 8;
    localparam int W = 32;
    localparam int S_HW = 0, S_VEC = 1, S_PEND = 2, S_ISV = 3, S_BUSY = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] irq, edge_mode, en_mask, pending, in_service;
    logic         imask, int_ack, eoi, hwint, busy;
    logic [W-1:0] vector;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_miscmp = 0;

    int_ctrl #(.NUM_IRQ(N), .WIDTH(W), .VEC_BASE(32'h0000_0010), .VEC_STRIDE(1)) dut (
        .clk(clk), .rst(rst), .irq(irq), .edge_mode(edge_mode), .en_mask(en_mask),
        .imask(imask), .int_ack(int_ack), .eoi(eoi), .hwint(hwint), .vector(vector),
        .pending(pending), .in_service(in_service), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            S_HW:    return {31'd0, hwint};
            S_VEC:   return vector;
            S_PEND:  return {24'd0, pending};
            S_ISV:   return {24'd0, in_service};
            default: return {31'd0, busy};
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [31:0] val);
        exp_t e;
        e.tag = tag; e.sel = sel; e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val(e.tag, observe(e.sel), e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        drain();
    endtask

    initial begin
        rst = 1'b1; irq = 8'h00; edge_mode = 8'hFF; en_mask = 8'hFF;
        imask = 1'b1; int_ack = 1'b0; eoi = 1'b0;
        push("rst_hw", S_HW, 32'd0); push("rst_vec", S_VEC, 32'd0);
        push("rst_pend", S_PEND, 32'd0); push("rst_isv", S_ISV, 32'd0);
        push("rst_busy", S_BUSY, 32'd0);
        #1 drain();
        @(negedge clk); rst = 1'b0;

        // ack while idle is ignored
        int_ack = 1'b1; push("idle_ack_isv", S_ISV, 32'h00); push("idle_ack_hw", S_HW, 32'd0); tick();
        int_ack = 1'b0;

        // 1: single edge source ch3
        irq = 8'h08; push("t1_pend", S_PEND, 32'h08); push("t1_hw0", S_HW, 32'd0); tick();
        irq = 8'h00; push("t1_hw", S_HW, 32'd1); push("t1_vec", S_VEC, 32'h13); tick();
        int_ack = 1'b1;
        push("t1_ack_hw", S_HW, 32'd0); push("t1_ack_pend", S_PEND, 32'h00);
        push("t1_ack_isv", S_ISV, 32'h08); push("t1_ack_busy", S_BUSY, 32'd1); tick();
        int_ack = 1'b0; eoi = 1'b1;
        push("t1_eoi_isv", S_ISV, 32'h00); push("t1_eoi_busy", S_BUSY, 32'd0); tick();
        eoi = 1'b0;

        // 2: simultaneous ch5/ch2; ch5 waits for ch2's eoi
        irq = 8'h24; push("t2_pend", S_PEND, 32'h24); tick();
        irq = 8'h00; push("t2_hw", S_HW, 32'd1); push("t2_vec", S_VEC, 32'h12); tick();
        int_ack = 1'b1; push("t2_isv", S_ISV, 32'h04); push("t2_pend2", S_PEND, 32'h20); tick();
        int_ack = 1'b0; push("t2_blocked", S_HW, 32'd0); tick();
        eoi = 1'b1; push("t2_eoi_isv", S_ISV, 32'h00); tick();
        eoi = 1'b0; push("t2_hw5", S_HW, 32'd1); push("t2_vec5", S_VEC, 32'h15); tick();
        int_ack = 1'b1; push("t2_isv5", S_ISV, 32'h20); tick();
        int_ack = 1'b0; eoi = 1'b1; push("t2_done", S_ISV, 32'h00); tick();
        eoi = 1'b0;

        // 3: nesting under ch4
        irq = 8'h10; tick();
        irq = 8'h00; push("t3_vec4", S_VEC, 32'h14); tick();
        int_ack = 1'b1; push("t3_isv4", S_ISV, 32'h10); tick();
        int_ack = 1'b0; irq = 8'h40; tick();
        irq = 8'h00; push("t3_nohw", S_HW, 32'd0); push("t3_pend6", S_PEND, 32'h40); tick();
        irq = 8'h02; tick();
        irq = 8'h00; push("t3_hw1", S_HW, 32'd1); push("t3_vec1", S_VEC, 32'h11); tick();
        int_ack = 1'b1; push("t3_isv12", S_ISV, 32'h12); tick();
        int_ack = 1'b0; eoi = 1'b1; push("t3_isv10", S_ISV, 32'h10); tick();
        push("t3_eoi2", S_ISV, 32'h00); tick();
        eoi = 1'b0; push("t3_vec6", S_VEC, 32'h16); tick();
        int_ack = 1'b1; tick();
        int_ack = 1'b0; eoi = 1'b1; push("t3_clean", S_PEND, 32'h00); tick();
        eoi = 1'b0;

        // 4: level ch0 held high
        edge_mode = 8'hFE; irq = 8'h01; tick();
        push("t4_hw", S_HW, 32'd1); push("t4_vec", S_VEC, 32'h10); tick();
        int_ack = 1'b1; push("t4_isv", S_ISV, 32'h01); push("t4_pend", S_PEND, 32'h01); tick();
        int_ack = 1'b0; push("t4_hw_blk", S_HW, 32'd0); tick();
        eoi = 1'b1; push("t4_eoi_hw", S_HW, 32'd0); push("t4_eoi_isv", S_ISV, 32'h00); tick();
        eoi = 1'b0; push("t4_rehw", S_HW, 32'd1); push("t4_revec", S_VEC, 32'h10); tick();
        irq = 8'h00; int_ack = 1'b1; push("t4_pend0", S_PEND, 32'h00); tick();
        int_ack = 1'b0; eoi = 1'b1; edge_mode = 8'hFF; push("t4_clean", S_ISV, 32'h00); tick();
        eoi = 1'b0;

        // 5: global and per-channel masking
        imask = 1'b0; irq = 8'h80; push("t5_pend", S_PEND, 32'h80); tick();
        irq = 8'h00; push("t5_nohw", S_HW, 32'd0); tick();
        imask = 1'b1; push("t5_hw", S_HW, 32'd1); push("t5_vec", S_VEC, 32'h17); tick();
        en_mask = 8'h7F; push("t5_wd_hw", S_HW, 32'd0); push("t5_wd_vec", S_VEC, 32'd0);
        push("t5_wd_pend", S_PEND, 32'h80); tick();
        en_mask = 8'hFF; push("t5_re_hw", S_HW, 32'd1); tick();
        int_ack = 1'b1; tick();
        int_ack = 1'b0; eoi = 1'b1; push("t5_clean", S_ISV, 32'h00); tick();
        eoi = 1'b0;

        // 7: same-cycle ack and eoi
        irq = 8'h10; tick();
        irq = 8'h00; tick();
        int_ack = 1'b1; tick();
        int_ack = 1'b0; irq = 8'h02; tick();
        irq = 8'h00; push("t7_vec1", S_VEC, 32'h11); tick();
        int_ack = 1'b1; eoi = 1'b1; push("t7_isv", S_ISV, 32'h02); tick();
        int_ack = 1'b0; push("t7_eoi", S_ISV, 32'h00); push("t7_busy", S_BUSY, 32'd0); tick();
        eoi = 1'b0;

        // 8: fresh edge on winner during ack is kept
        irq = 8'h08; tick();
        irq = 8'h00; tick();
        irq = 8'h08; int_ack = 1'b1; push("t8_pend", S_PEND, 32'h08); push("t8_isv", S_ISV, 32'h08); tick();
        irq = 8'h00; int_ack = 1'b0; eoi = 1'b1; tick();
        eoi = 1'b0; push("t8_hw", S_HW, 32'd1); push("t8_vec", S_VEC, 32'h13); tick();
        int_ack = 1'b1; push("t8_pend0", S_PEND, 32'h00); tick();
        int_ack = 1'b0; eoi = 1'b1; tick();
        eoi = 1'b0;

        // 6: async reset while requesting, then no spurious edge
        irq = 8'h04; tick();
        irq = 8'h00; tick();
        int_ack = 1'b1; tick();
        int_ack = 1'b0; irq = 8'h01; tick();
        push("t6_hw", S_HW, 32'd1); push("t6_isv", S_ISV, 32'h04); tick();
        #2 rst = 1'b1;
        push("t6_r_hw", S_HW, 32'd0); push("t6_r_vec", S_VEC, 32'd0); push("t6_r_pend", S_PEND, 32'd0);
        push("t6_r_isv", S_ISV, 32'd0); push("t6_r_busy", S_BUSY, 32'd0);
        #1 drain();
        @(negedge clk); rst = 1'b0;
        push("t6_nopend", S_PEND, 32'h00); tick();
        push("t6_nohw", S_HW, 32'd0); push("t6_nopend2", S_PEND, 32'h00); tick();
        irq = 8'h00; tick();
        irq = 8'h01; push("t6_newpend", S_PEND, 32'h01); tick();
        push("t6_newhw", S_HW, 32'd1); push("t6_newvec", S_VEC, 32'h10); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end
endmodule
